// File: rtl/alu_status_unit_if.sv
// Execute-stage bus between the issue logic and the ALU/status unit.
// The master drives the operation; the slave returns the registered result and flags.
interface alu_status_unit_if #(
  parameter int WIDTH = 32
);
  logic             valid_in;
  logic             stall;
  logic             flush;
  logic [3:0]       exe_cmd;
  logic             s_update;
  logic [WIDTH-1:0] val1;
  logic [WIDTH-1:0] val2;
  logic [WIDTH-1:0] result;
  logic             valid_out;
  logic             N;
  logic             Z;
  logic             C;
  logic             V;

  modport master (
    output valid_in, stall, flush, exe_cmd, s_update, val1, val2,
    input  result, valid_out, N, Z, C, V
  );

  modport slave (
    input  valid_in, stall, flush, exe_cmd, s_update, val1, val2,
    output result, valid_out, N, Z, C, V
  );
endinterface

// File: rtl/alu_status_unit.sv
// Execute-stage ALU with a registered result and the NZCV status register.
// ADC/SBC read the carry from the flag register as it stands, so no bypass exists.
module alu_status_unit #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  alu_status_unit_if.slave   bus
);
  localparam int MSB = WIDTH - 1;

  logic [WIDTH-1:0] result_q;
  logic             valid_q;
  logic             n_q, z_q, c_q, v_q;

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] alu_res;
  logic             c_next, v_next;
  logic             commit;

  // Logical ops leave c_next/v_next at the held values, so only N and Z move.
  always_comb begin
    sum     = '0;
    alu_res = '0;
    c_next  = c_q;
    v_next  = v_q;
    case (bus.exe_cmd)
      4'b0001: alu_res = bus.val2;
      4'b1001: alu_res = ~bus.val2;
      4'b0010, 4'b0011: begin
        sum     = {1'b0, bus.val1} + {1'b0, bus.val2}
                + {{WIDTH{1'b0}}, (bus.exe_cmd[0] & c_q)};
        alu_res = sum[MSB:0];
        c_next  = sum[WIDTH];
        v_next  = (bus.val1[MSB] == bus.val2[MSB]) && (alu_res[MSB] != bus.val1[MSB]);
      end
      4'b0100, 4'b0101: begin
        sum     = {1'b0, bus.val1} - {1'b0, bus.val2}
                - {{WIDTH{1'b0}}, (bus.exe_cmd[0] & ~c_q)};
        alu_res = sum[MSB:0];
        c_next  = ~sum[WIDTH];
        v_next  = (bus.val1[MSB] != bus.val2[MSB]) && (alu_res[MSB] != bus.val1[MSB]);
      end
      4'b0110: alu_res = bus.val1 & bus.val2;
      4'b0111: alu_res = bus.val1 | bus.val2;
      4'b1000: alu_res = bus.val1 ^ bus.val2;
      default: alu_res = '0;
    endcase
  end

  assign commit = bus.valid_in && !bus.stall && !bus.flush;

  // Flush beats stall: a squashed slot always drops valid_out and never writes flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= '0;
      valid_q  <= 1'b0;
      n_q      <= 1'b0;
      z_q      <= 1'b0;
      c_q      <= 1'b0;
      v_q      <= 1'b0;
    end else if (bus.flush) begin
      valid_q <= 1'b0;
    end else if (!bus.stall) begin
      valid_q <= commit;
      if (commit) begin
        result_q <= alu_res;
        if (bus.s_update) begin
          n_q <= alu_res[MSB];
          z_q <= (alu_res == '0);
          c_q <= c_next;
          v_q <= v_next;
        end
      end
    end
  end

  assign bus.result    = result_q;
  assign bus.valid_out = valid_q;
  assign bus.N         = n_q;
  assign bus.Z         = z_q;
  assign bus.C         = c_q;
  assign bus.V         = v_q;
endmodule

// File: tb/tb_alu_status_unit.sv
// Self-checking bench for alu_status_unit: directed vector table, hand-written
// stall/flush/reset sequences, and randomized traffic against an arithmetic model.
module tb_alu_status_unit;
  localparam logic [3:0] OP_MOV = 4'b0001;
  localparam logic [3:0] OP_MVN = 4'b1001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_ADC = 4'b0011;
  localparam logic [3:0] OP_SUB = 4'b0100;
  localparam logic [3:0] OP_SBC = 4'b0101;
  localparam logic [3:0] OP_AND = 4'b0110;
  localparam logic [3:0] OP_ORR = 4'b0111;
  localparam logic [3:0] OP_EOR = 4'b1000;
  localparam logic [3:0] OP_BAD = 4'b0000;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  alu_status_unit_if #(.WIDTH(32)) bus ();

  alu_status_unit #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference state, advanced once per clock edge from the instruction-set rules.
  logic [31:0] m_result;
  logic        m_valid, m_n, m_z, m_c, m_v;

  task automatic model_clock(input logic r, input logic vi, input logic st, input logic fl,
                             input logic [3:0] cmd, input logic s,
                             input logic [31:0] a, input logic [31:0] b);
    longint      wide;
    longint      sres;
    logic [31:0] res;
    logic        nc, nv;
    longint      cin;
    if (r) begin
      m_result = 32'd0; m_valid = 1'b0;
      m_n = 1'b0; m_z = 1'b0; m_c = 1'b0; m_v = 1'b0;
      return;
    end
    if (fl) begin m_valid = 1'b0; return; end
    if (st) return;
    if (!vi) begin m_valid = 1'b0; return; end
    nc  = m_c;
    nv  = m_v;
    res = 32'd0;
    case (cmd)
      OP_MOV: res = b;
      OP_MVN: res = ~b;
      OP_ADD, OP_ADC: begin
        cin  = (cmd == OP_ADC && m_c) ? 64'sd1 : 64'sd0;
        wide = longint'({32'd0, a}) + longint'({32'd0, b}) + cin;
        res  = wide[31:0];
        nc   = (wide >= 64'sd4294967296);
        sres = longint'($signed(a)) + longint'($signed(b)) + cin;
        nv   = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
      end
      OP_SUB, OP_SBC: begin
        cin  = (cmd == OP_SBC && !m_c) ? 64'sd1 : 64'sd0;
        wide = longint'({32'd0, a}) - longint'({32'd0, b}) - cin;
        res  = wide[31:0];
        nc   = (wide >= 64'sd0);
        sres = longint'($signed(a)) - longint'($signed(b)) - cin;
        nv   = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
      end
      OP_AND: res = a & b;
      OP_ORR: res = a | b;
      OP_EOR: res = a ^ b;
      default: res = 32'd0;
    endcase
    m_result = res;
    m_valid  = 1'b1;
    if (s) begin
      m_n = res[31];
      m_z = (res == 32'd0);
      m_c = nc;
      m_v = nv;
    end
  endtask

  // Drives one cycle of inputs, advances the model, and returns #1 after the edge.
  task automatic apply_stimulus(input logic r, input logic vi, input logic st, input logic fl,
                                input logic [3:0] cmd, input logic s,
                                input logic [31:0] a, input logic [31:0] b);
    rst          = r;
    bus.valid_in = vi;
    bus.stall    = st;
    bus.flush    = fl;
    bus.exe_cmd  = cmd;
    bus.s_update = s;
    bus.val1     = a;
    bus.val2     = b;
    model_clock(r, vi, st, fl, cmd, s, a, b);
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [31:0] res, input logic vo,
                              input logic n, input logic z, input logic c, input logic v);
    logic [36:0] got, want;
    got  = {bus.result, bus.valid_out, bus.N, bus.Z, bus.C, bus.V};
    want = {res, vo, n, z, c, v};
    checks++;
    if (got !== want) begin
      failures++;
      $display("[TB] FAIL %s: got result=%h valid=%b NZCV=%b%b%b%b, want result=%h valid=%b NZCV=%b%b%b%b",
               name, bus.result, bus.valid_out, bus.N, bus.Z, bus.C, bus.V,
               res, vo, n, z, c, v);
    end
  endtask

  typedef struct {
    logic [3:0]  cmd;
    logic        s;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        n, z, c, v;
  } vec_t;

  vec_t vecs [16];

  initial begin
    checks   = 0;
    failures = 0;

    // Each row depends on the flags left by the row before it.
    vecs[0]  = '{OP_ADD, 1'b1, 32'hFFFF_FFFF, 32'h1,         32'h0,         1'b0, 1'b1, 1'b1, 1'b0};
    vecs[1]  = '{OP_ADC, 1'b1, 32'h5,         32'h3,         32'h9,         1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{OP_SUB, 1'b1, 32'h8000_0000, 32'h1,         32'h7FFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[3]  = '{OP_AND, 1'b1, 32'hF0,        32'h0F,        32'h0,         1'b0, 1'b1, 1'b1, 1'b1};
    vecs[4]  = '{OP_ADD, 1'b1, 32'h1,         32'h1,         32'h2,         1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{OP_ADD, 1'b0, 32'hFFFF_FFFF, 32'h1,         32'h0,         1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{OP_ADC, 1'b1, 32'h5,         32'h3,         32'h8,         1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{OP_MVN, 1'b1, 32'h0,         32'h0,         32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{OP_SBC, 1'b1, 32'h5,         32'h3,         32'h1,         1'b0, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{OP_SBC, 1'b1, 32'h5,         32'h3,         32'h2,         1'b0, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{OP_ORR, 1'b1, 32'h0F00,      32'h00F0,      32'h0FF0,      1'b0, 1'b0, 1'b1, 1'b0};
    vecs[11] = '{OP_EOR, 1'b1, 32'hFFFF_FFFF, 32'h0,         32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[12] = '{OP_BAD, 1'b1, 32'h5,         32'h7,         32'h0,         1'b0, 1'b1, 1'b1, 1'b0};
    vecs[13] = '{OP_MOV, 1'b0, 32'h0,         32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[14] = '{OP_ADD, 1'b1, 32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[15] = '{OP_SUB, 1'b1, 32'h3,         32'h5,         32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0, 1'b0};

    rst = 1'b1;
    bus.valid_in = 1'b0; bus.stall = 1'b0; bus.flush = 1'b0;
    bus.exe_cmd = 4'd0; bus.s_update = 1'b0; bus.val1 = '0; bus.val2 = '0;
    @(negedge clk);
    apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, OP_ADD, 1'b1, 32'h1234, 32'h1);
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, OP_MOV, 1'b0, 32'h0, 32'h0);
    check_output("reset", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 16; i++) begin
      apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, vecs[i].cmd, vecs[i].s, vecs[i].a, vecs[i].b);
      check_output($sformatf("vec%0d", i), vecs[i].res, 1'b1,
                   vecs[i].n, vecs[i].z, vecs[i].c, vecs[i].v);
    end

    // Stall for three cycles: everything frozen at the SUB 3-5 state, then ADD 2+3 lands.
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0, OP_ADD, 1'b1, 32'h2, 32'h3);
      check_output($sformatf("stall%0d", i), 32'hFFFF_FFFE, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, OP_ADD, 1'b1, 32'h2, 32'h3);
    check_output("stall_release", 32'h5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, OP_SUB, 1'b1, 32'h3, 32'h5);
    check_output("pre_flush", 32'hFFFF_FFFE, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    apply_stimulus(1'b0, 1'b1, 1'b1, 1'b1, OP_ADD, 1'b1, 32'h2, 32'h3);
    check_output("flush_stall", 32'hFFFF_FFFE, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b1, OP_ADD, 1'b1, 32'h2, 32'h3);
    check_output("flush_only", 32'hFFFF_FFFE, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, OP_ADD, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check_output("pre_reset", 32'hFFFF_FFFE, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    apply_stimulus(1'b1, 1'b1, 1'b1, 1'b0, OP_ADD, 1'b1, 32'h1, 32'h1);
    check_output("reset_midstream", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Randomized traffic; operands are biased toward the sign and carry boundaries.
    for (int i = 0; i < 400; i++) begin
      logic        r, vi, st, fl, s;
      logic [3:0]  cmd;
      logic [31:0] a, b;
      r   = ($urandom_range(0, 99) == 0);
      vi  = ($urandom_range(0, 9) != 0);
      st  = ($urandom_range(0, 7) == 0);
      fl  = ($urandom_range(0, 11) == 0);
      s   = ($urandom_range(0, 3) != 0);
      cmd = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 3))
        0:       a = 32'hFFFF_FFFF;
        1:       a = 32'h8000_0000 - 32'($urandom_range(0, 1));
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 3))
        0:       b = 32'($urandom_range(0, 2));
        1:       b = a;
        default: b = $urandom;
      endcase
      apply_stimulus(r, vi, st, fl, cmd, s, a, b);
      check_output($sformatf("rand%0d", i), m_result, m_valid, m_n, m_z, m_c, m_v);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu_status_unit.md
# alu_status_unit

Execute-stage ALU with a registered result and the architectural status register. It sits directly upstream of the condition-check logic: its N, Z, C, V outputs are the registered flags the condition checker evaluates against each instruction's 4-bit condition field. It also supplies the carry-in for ADC/SBC, so back-to-back flag-dependent instructions see correctly sequenced flags.

## Interface
- WIDTH, 32, datapath width in bits.

- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- valid_in  input  1  operation presented this cycle is real.
- stall  input  1  hold all state; accept nothing.
- flush  input  1  squash the operation presented this cycle.
- exe_cmd  input  4  operation select (see Operation).
- s_update  input  1  S bit; commit flags for this operation.
- val1  input  WIDTH  first operand (Rn).
- val2  input  WIDTH  second operand (shifter output).
- result  output  WIDTH  registered ALU result.
- valid_out  output  1  result holds a committed operation.
- N, Z, C, V  output  1 each  registered status flags, direct to condition check.

## Operation
- Opcodes:
  - 0001 MOV: val2.
  - 1001 MVN: ~val2.
  - 0010 ADD: val1+val2.
  - 0011 ADC: val1+val2+C.
  - 0100 SUB/CMP: val1−val2.
  - 0101 SBC: val1−val2−(~C).
  - 0110 AND/TST: val1&val2.
  - 0111 ORR: val1|val2.
  - 1000 EOR: val1^val2.
  - Any other code: result 0, flags treated as logical.
- Arithmetic is computed at WIDTH+1 bits.
- C:
  - Add ops: C = bit WIDTH of the sum.
  - Sub ops: C = NOT borrow (1 when the unsigned result does not underflow, e.g. val1 ≥ val2 for SUB).
- V:
  - Add: operands have the same sign and the result sign differs.
  - Sub: operand signs differ and the result sign differs from val1.
- N = result[WIDTH-1]; Z = (result == 0).
- Logical ops and MOV/MVN update only N and Z; C and V hold.
- A cycle commits when valid_in=1, stall=0, flush=0. On commit:
  - result and valid_out<=1 load.
  - Flags load only if s_update=1.
- A non-committing cycle with stall=0 (flush=1 or valid_in=0) sets valid_out<=0. result holds its old value, and flags hold.
- While stall=1 and flush=0, result, valid_out and flags all hold.
- Priority: rst > flush > stall > normal.
- ADC/SBC always take the flag register value as it stands at the current edge. The flag write from the previous committing instruction is therefore visible to the next cycle's instruction; no bypass is needed.

## Timing
- Reset: result=0, valid_out=0, N=Z=C=V=0, effective on the first rising edge with rst=1.
- Latency is 1 cycle: operands at edge k appear on result and flags after edge k.
- Throughput is one operation per cycle when not stalled.
- Flags change only on edges where a committing flag-setting operation is presented. They are stable for the whole following cycle, so the combinational condition check downstream never sees glitching state.
- stall and flush asserted together: the flush wins, valid_out<=0, and flags are not written.
- Asserting rst during a stall or while an operation is presented clears everything; the presented operation is lost.
- Wrap-around: results are truncated to WIDTH bits; C and V capture the overflow.

## Test plan
- Reset, then ADD with val1=0xFFFFFFFF, val2=1, s_update=1 -> result=0; Z=1, C=1, N=0, V=0 one cycle later; valid_out=1.
- SUB with val1=0x80000000, val2=1, s_update=1 -> result=0x7FFFFFFF; N=0, Z=0, C=1, V=1.
- ADD 0xFFFFFFFF+1 with s_update=1, then ADC 5+3 on the next cycle -> second result=9 (C=1 consumed).
  - Repeat with s_update=0 on the first op -> second result=8.
- Set C=1, V=1 via SUB 0x80000000−1, then AND 0xF0 & 0x0F with s_update=1 -> result=0; Z=1, N=0; C=1 and V=1 unchanged.
- ADD 2+3 with stall=1 for 3 cycles, then released -> result, valid_out and flags frozen during the stall; result=5 one cycle after release.
  - Same op with flush=1 and stall=1 -> valid_out=0, flags unchanged.
- Assert rst mid-stream after flags N=1, C=1 -> next cycle result=0, valid_out=0, N=Z=C=V=0.
